// File: rtl/trig_type_lv1a_delta_gen.sv
// Delta-pattern LV1A trigger type: isolated one-sample pulses on the ET sum and veto vector,
// coincidence window, prescaler, single/multi-shot issue with holdoff, per-live-period diagnostics.
module trig_type_lv1a_delta_gen #(
    parameter int ET_W    = 16,
    parameter int VETO_W  = 32,
    parameter int CNT_W   = 9,
    parameter int CNT_MAX = 510,
    parameter int WIN_W   = 4,
    parameter int PS_W    = 8,
    parameter int HO_W    = 8,
    parameter int NCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ET_W:0]     in_et,
    input  logic [VETO_W-1:0] in_veto,
    input  logic              in_live,
    input  logic              in_ena,
    input  logic              user_ena,
    input  logic              multi_ena,
    input  logic [ET_W-1:0]   delta_et_thre,
    input  logic [VETO_W-1:0] delta_veto_ptn,
    input  logic [WIN_W-1:0]  coin_win,
    input  logic [PS_W-1:0]   prescale,
    input  logic [HO_W-1:0]   holdoff,
    output logic              out_lv1a,
    output logic [ET_W-1:0]   et_raw,
    output logic [VETO_W-1:0] veto_raw,
    output logic [NCNT_W-1:0] ndelta,
    output logic [NCNT_W-1:0] ntrig,
    output logic [CNT_W-1:0]  delay_et,
    output logic [CNT_W-1:0]  delay_veto
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_FIRE    = 3'd2;
    localparam logic [2:0] ST_HOLDOFF = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(CNT_MAX);
    localparam logic [NCNT_W-1:0] NCNT_ONE = NCNT_W'(1);

    logic [ET_W:0]       et_s0_reg, et_s1_reg, et_s2_reg;
    logic [VETO_W-1:0]   veto_s0_reg, veto_s1_reg, veto_s2_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    t_et_reg, t_veto_reg;
    logic [CNT_W-1:0]    t_et_next, t_veto_next;
    logic [WIN_W-1:0]    et_timer_reg, veto_timer_reg;
    logic [PS_W-1:0]     ps_cnt_reg;
    logic [HO_W-1:0]     ho_cnt_reg;
    logic [2:0]          state_reg;
    logic                live_d_reg;
    logic                out_reg;
    logic [ET_W-1:0]     et_raw_reg;
    logic [VETO_W-1:0]   veto_raw_reg;
    logic [NCNT_W-1:0]   ndelta_reg, ntrig_reg;
    logic [CNT_W-1:0]    delay_et_reg, delay_veto_reg;

    logic [VETO_W-1:0]   veto_match;
    logic                eval_ena;
    logic                live_rise;
    logic                et_delta;
    logic                veto_delta;
    logic                coin;
    logic                armed_hit;
    logic                fire;

    assign eval_ena  = in_live & in_ena;
    assign live_rise = in_live & ~live_d_reg;

    // A veto bit matches when the pattern does not require it or the sample has it set.
    genvar gi;
    generate
        for (gi = 0; gi < VETO_W; gi++) begin : g_veto_match
            assign veto_match[gi] = ~delta_veto_ptn[gi] | veto_s1_reg[gi];
        end
    endgenerate

    assign et_delta = eval_ena
                   && (et_s2_reg == '0)
                   && et_s1_reg[ET_W]
                   && (et_s1_reg[ET_W-1:0] > delta_et_thre)
                   && (et_s0_reg == '0);

    // An all-zero pattern would otherwise match an empty sample, so demand some activity.
    assign veto_delta = eval_ena
                     && (veto_s2_reg == '0)
                     && (&veto_match)
                     && ((delta_veto_ptn != '0) || (veto_s1_reg != '0))
                     && (veto_s0_reg == '0);

    assign coin = (et_delta && (veto_delta || (veto_timer_reg != '0)))
               || (veto_delta && (et_timer_reg != '0));

    assign armed_hit = coin && user_ena && (state_reg == ST_ARMED);
    // >= keeps the prescaler from running away if prescale is lowered mid-count.
    assign fire      = armed_hit && (ps_cnt_reg >= prescale);

    // Bypass so a trigger completed by a delta in this cycle reports this cycle's count.
    assign t_et_next   = et_delta   ? cnt_reg : t_et_reg;
    assign t_veto_next = veto_delta ? cnt_reg : t_veto_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            et_s0_reg   <= '0;
            et_s1_reg   <= '0;
            et_s2_reg   <= '0;
            veto_s0_reg <= '0;
            veto_s1_reg <= '0;
            veto_s2_reg <= '0;
            live_d_reg  <= 1'b0;
        end else begin
            live_d_reg <= in_live;
            if (!in_live) begin
                et_s0_reg   <= '0;
                et_s1_reg   <= '0;
                et_s2_reg   <= '0;
                veto_s0_reg <= '0;
                veto_s1_reg <= '0;
                veto_s2_reg <= '0;
            end else begin
                et_s0_reg   <= in_et;
                et_s1_reg   <= et_s0_reg;
                et_s2_reg   <= et_s1_reg;
                veto_s0_reg <= in_veto;
                veto_s1_reg <= veto_s0_reg;
                veto_s2_reg <= veto_s1_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            t_et_reg       <= '0;
            t_veto_reg     <= '0;
            et_timer_reg   <= '0;
            veto_timer_reg <= '0;
        end else if (!in_live) begin
            cnt_reg        <= '0;
            t_et_reg       <= '0;
            t_veto_reg     <= '0;
            et_timer_reg   <= '0;
            veto_timer_reg <= '0;
        end else if (in_ena) begin
            if (cnt_reg < CNT_SAT) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            t_et_reg   <= t_et_next;
            t_veto_reg <= t_veto_next;
            // Coincidence consumes both deltas so neither can pair a second time.
            if (coin) begin
                et_timer_reg   <= '0;
                veto_timer_reg <= '0;
            end else begin
                if (et_delta) begin
                    et_timer_reg <= coin_win;
                end else if (et_timer_reg != '0) begin
                    et_timer_reg <= et_timer_reg - WIN_W'(1);
                end
                if (veto_delta) begin
                    veto_timer_reg <= coin_win;
                end else if (veto_timer_reg != '0) begin
                    veto_timer_reg <= veto_timer_reg - WIN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_reg <= '0;
        end else if (!in_live) begin
            ps_cnt_reg <= '0;
        end else if (armed_hit) begin
            ps_cnt_reg <= fire ? '0 : ps_cnt_reg + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ho_cnt_reg <= '0;
            out_reg    <= 1'b0;
        end else if (!in_live) begin
            state_reg  <= ST_IDLE;
            ho_cnt_reg <= '0;
            out_reg    <= 1'b0;
        end else begin
            out_reg <= fire;
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (fire) begin
                        state_reg <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    if (in_ena) begin
                        if (multi_ena) begin
                            state_reg  <= ST_HOLDOFF;
                            ho_cnt_reg <= holdoff;
                        end else begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (in_ena) begin
                        if (ho_cnt_reg == '0) begin
                            state_reg <= ST_ARMED;
                        end else begin
                            ho_cnt_reg <= ho_cnt_reg - HO_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Diagnostics survive a dead period and are only wiped when the next live period opens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            et_raw_reg     <= '0;
            veto_raw_reg   <= '0;
            ndelta_reg     <= '0;
            ntrig_reg      <= '0;
            delay_et_reg   <= '0;
            delay_veto_reg <= '0;
        end else if (live_rise) begin
            et_raw_reg     <= '0;
            veto_raw_reg   <= '0;
            ndelta_reg     <= '0;
            ntrig_reg      <= '0;
            delay_et_reg   <= '0;
            delay_veto_reg <= '0;
        end else begin
            if (et_delta) begin
                et_raw_reg <= et_s1_reg[ET_W-1:0];
            end
            if (veto_delta) begin
                veto_raw_reg <= veto_s1_reg;
            end
            if (coin && (ndelta_reg != '1)) begin
                ndelta_reg <= ndelta_reg + NCNT_ONE;
            end
            if (fire) begin
                delay_et_reg   <= t_et_next;
                delay_veto_reg <= t_veto_next;
                if (ntrig_reg != '1) begin
                    ntrig_reg <= ntrig_reg + NCNT_ONE;
                end
            end
        end
    end

    assign out_lv1a   = out_reg;
    assign et_raw     = et_raw_reg;
    assign veto_raw   = veto_raw_reg;
    assign ndelta     = ndelta_reg;
    assign ntrig      = ntrig_reg;
    assign delay_et   = delay_et_reg;
    assign delay_veto = delay_veto_reg;

endmodule

// File: tb/tb_trig_type_lv1a_delta_gen.sv
// Bench for trig_type_lv1a_delta_gen: expected pulse cycles queued at stimulus time,
// popped and compared by a monitor when out_lv1a rises.
module tb_trig_type_lv1a_delta_gen;

    localparam int ET_W   = 16;
    localparam int VETO_W = 32;
    localparam int CNT_W  = 9;
    localparam int WIN_W  = 4;
    localparam int PS_W   = 8;
    localparam int HO_W   = 8;
    localparam int NCNT_W = 16;

    logic              clk;
    logic              rst_n;
    logic [ET_W:0]     in_et;
    logic [VETO_W-1:0] in_veto;
    logic              in_live;
    logic              in_ena;
    logic              user_ena;
    logic              multi_ena;
    logic [ET_W-1:0]   delta_et_thre;
    logic [VETO_W-1:0] delta_veto_ptn;
    logic [WIN_W-1:0]  coin_win;
    logic [PS_W-1:0]   prescale;
    logic [HO_W-1:0]   holdoff;
    logic              out_lv1a;
    logic [ET_W-1:0]   et_raw;
    logic [VETO_W-1:0] veto_raw;
    logic [NCNT_W-1:0] ndelta;
    logic [NCNT_W-1:0] ntrig;
    logic [CNT_W-1:0]  delay_et;
    logic [CNT_W-1:0]  delay_veto;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int live_cyc = 0;
    int last_t0 = 0;
    int mon_exp = 0;
    int exp_q[$];

    trig_type_lv1a_delta_gen dut (
        .clk(clk), .rst_n(rst_n), .in_et(in_et), .in_veto(in_veto),
        .in_live(in_live), .in_ena(in_ena), .user_ena(user_ena), .multi_ena(multi_ena),
        .delta_et_thre(delta_et_thre), .delta_veto_ptn(delta_veto_ptn), .coin_win(coin_win),
        .prescale(prescale), .holdoff(holdoff), .out_lv1a(out_lv1a), .et_raw(et_raw),
        .veto_raw(veto_raw), .ndelta(ndelta), .ntrig(ntrig), .delay_et(delay_et),
        .delay_veto(delay_veto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every pulse must match the oldest queued cycle.
    always @(negedge clk) begin
        if (out_lv1a === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL lv1a_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cyc != mon_exp) begin
                    fails++;
                    $display("FAIL lv1a_cycle: pulse at cycle %0d, required cycle %0d", cyc, mon_exp);
                end else begin
                    $display("[TB] lv1a pulse at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic set_regs(input logic [WIN_W-1:0] cw, input logic [PS_W-1:0] ps,
                            input logic [HO_W-1:0] ho, input logic me);
        in_ena         = 1'b1;
        user_ena       = 1'b1;
        delta_et_thre  = 16'h0100;
        delta_veto_ptn = 32'h0000_000F;
        coin_win       = cw;
        prescale       = ps;
        holdoff        = ho;
        multi_ena      = me;
    endtask

    task automatic relive();
        @(negedge clk);
        in_live = 1'b0;
        @(negedge clk);
        in_live  = 1'b1;
        live_cyc = cyc;
        @(negedge clk);
    endtask

    // ET pulse at t=0, veto pulse at t=gap; a fire is expected 3 cycles after the later one.
    task automatic send_pair(input logic [ET_W:0] e, input logic [VETO_W-1:0] v, input int gap,
                             input bit wide, input bit exp_fire, input int idle);
        for (int t = 0; t <= gap + 2; t++) begin
            @(negedge clk);
            if (t == 0) begin
                last_t0 = cyc;
                if (exp_fire) exp_q.push_back(cyc + gap + 3);
            end
            in_et   = (t == 0 || (wide && t == 1)) ? e : '0;
            in_veto = (t == gap) ? v : '0;
        end
        repeat (idle) @(negedge clk);
        $display("[TB] pair et=%h veto=%h gap=%0d wide=%0d cycle=%0d expect_fire=%0d",
                 e, v, gap, wide, last_t0, exp_fire);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_et = '0; in_veto = '0; in_live = 1'b0;
        set_regs(4'd0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        tests++; if (out_lv1a !== 1'b0) begin fails++; $display("FAIL reset_lv1a: got %b required 0", out_lv1a); end
        tests++; if (et_raw !== '0) begin fails++; $display("FAIL reset_et_raw: got %h required 0", et_raw); end
        tests++; if (veto_raw !== '0) begin fails++; $display("FAIL reset_veto_raw: got %h required 0", veto_raw); end
        tests++; if (ndelta !== '0) begin fails++; $display("FAIL reset_ndelta: got %0d required 0", ndelta); end
        tests++; if (ntrig !== '0) begin fails++; $display("FAIL reset_ntrig: got %0d required 0", ntrig); end
        tests++; if (delay_et !== '0 || delay_veto !== '0) begin fails++; $display("FAIL reset_delay: got %0d/%0d required 0/0", delay_et, delay_veto); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_shot();
        set_regs(4'd0, 8'd0, 8'd0, 1'b0);
        relive();
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, 1'b1, 4);
        tests++; if (ndelta !== 16'd1) begin fails++; $display("FAIL single_ndelta: got %0d required 1", ndelta); end
        tests++; if (ntrig !== 16'd1) begin fails++; $display("FAIL single_ntrig: got %0d required 1", ntrig); end
        tests++; if (et_raw !== 16'h0200) begin fails++; $display("FAIL single_et_raw: got %h required 0200", et_raw); end
        tests++; if (veto_raw !== 32'hFF) begin fails++; $display("FAIL single_veto_raw: got %h required ff", veto_raw); end
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, 1'b0, 4);
        tests++; if (ndelta !== 16'd2) begin fails++; $display("FAIL single_ndelta2: got %0d required 2", ndelta); end
        tests++; if (ntrig !== 16'd1) begin fails++; $display("FAIL single_ntrig2: got %0d required 1", ntrig); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL single_pending: got %0d pulses missing required 0", exp_q.size()); end
    endtask

    task automatic test_window();
        int diff;
        set_regs(4'd2, 8'd0, 8'd0, 1'b0);
        relive();
        send_pair(17'h1_0300, 32'h0000_000F, 3, 1'b0, 1'b0, 6);
        tests++; if (ndelta !== 16'd0) begin fails++; $display("FAIL window2_ndelta: got %0d required 0", ndelta); end
        coin_win = 4'd3;
        send_pair(17'h1_0300, 32'h0000_000F, 3, 1'b0, 1'b1, 6);
        tests++; if (ndelta !== 16'd1) begin fails++; $display("FAIL window3_ndelta: got %0d required 1", ndelta); end
        diff = int'(delay_veto) - int'(delay_et);
        tests++; if (diff != 3) begin fails++; $display("FAIL window3_delay_diff: got %0d required 3", diff); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL window_pending: got %0d pulses missing required 0", exp_q.size()); end
    endtask

    task automatic test_threshold();
        set_regs(4'd0, 8'd0, 8'd0, 1'b0);
        relive();
        send_pair(17'h1_0100, 32'h0000_00FF, 0, 1'b0, 1'b0, 4);
        tests++; if (ndelta !== 16'd0) begin fails++; $display("FAIL thre_equal_ndelta: got %0d required 0", ndelta); end
        tests++; if (et_raw !== 16'h0000) begin fails++; $display("FAIL thre_equal_et_raw: got %h required 0000", et_raw); end
        send_pair(17'h1_0101, 32'h0000_00FF, 0, 1'b0, 1'b1, 4);
        tests++; if (ndelta !== 16'd1) begin fails++; $display("FAIL thre_plus1_ndelta: got %0d required 1", ndelta); end
        tests++; if (et_raw !== 16'h0101) begin fails++; $display("FAIL thre_plus1_et_raw: got %h required 0101", et_raw); end
        send_pair(17'h0_0200, 32'h0000_00FF, 0, 1'b0, 1'b0, 4);
        tests++; if (et_raw !== 16'h0101 || ndelta !== 16'd1) begin fails++; $display("FAIL thre_invalid: got et_raw=%h ndelta=%0d required 0101/1", et_raw, ndelta); end
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b1, 1'b0, 4);
        tests++; if (et_raw !== 16'h0101 || ndelta !== 16'd1) begin fails++; $display("FAIL thre_wide: got et_raw=%h ndelta=%0d required 0101/1", et_raw, ndelta); end
    endtask

    task automatic test_prescale();
        set_regs(4'd0, 8'd2, 8'd0, 1'b1);
        relive();
        for (int k = 0; k < 9; k++) begin
            send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, (k % 3) == 2, 7);
        end
        tests++; if (ntrig !== 16'd3) begin fails++; $display("FAIL prescale_ntrig: got %0d required 3", ntrig); end
        tests++; if (ndelta !== 16'd9) begin fails++; $display("FAIL prescale_ndelta: got %0d required 9", ndelta); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL prescale_pending: got %0d pulses missing required 0", exp_q.size()); end
    endtask

    task automatic test_holdoff();
        set_regs(4'd0, 8'd0, 8'd20, 1'b1);
        relive();
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, 1'b1, 7);
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, 1'b0, 12);
        tests++; if (ndelta !== 16'd2 || ntrig !== 16'd1) begin fails++; $display("FAIL holdoff_blocked: got ndelta=%0d ntrig=%0d required 2/1", ndelta, ntrig); end
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, 1'b1, 4);
        tests++; if (ndelta !== 16'd3 || ntrig !== 16'd2) begin fails++; $display("FAIL holdoff_rearmed: got ndelta=%0d ntrig=%0d required 3/2", ndelta, ntrig); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL holdoff_pending: got %0d pulses missing required 0", exp_q.size()); end
    endtask

    task automatic test_live_and_reset();
        int exp_delay;
        set_regs(4'd10, 8'd0, 8'd0, 1'b0);
        relive();
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, 1'b1, 4);
        send_pair(17'h1_0345, 32'h0000_0000, 0, 1'b0, 1'b0, 1);
        tests++; if (et_raw !== 16'h0345 || ntrig !== 16'd1) begin fails++; $display("FAIL live_before_drop: got et_raw=%h ntrig=%0d required 0345/1", et_raw, ntrig); end
        relive();
        tests++; if (et_raw !== '0 || veto_raw !== '0) begin fails++; $display("FAIL live_clear_raw: got %h/%h required 0/0", et_raw, veto_raw); end
        tests++; if (ndelta !== '0 || ntrig !== '0) begin fails++; $display("FAIL live_clear_counts: got %0d/%0d required 0/0", ndelta, ntrig); end
        tests++; if (delay_et !== '0 || delay_veto !== '0) begin fails++; $display("FAIL live_clear_delay: got %0d/%0d required 0/0", delay_et, delay_veto); end
        send_pair(17'h0_0000, 32'h0000_00FF, 0, 1'b0, 1'b0, 4);
        tests++; if (ndelta !== '0) begin fails++; $display("FAIL live_window_cleared: got ndelta=%0d required 0", ndelta); end
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, 1'b1, 4);
        exp_delay = last_t0 - live_cyc + 2;
        tests++; if (int'(delay_et) != exp_delay || int'(delay_veto) != exp_delay) begin fails++; $display("FAIL live_cnt_restart: got %0d/%0d required %0d", delay_et, delay_veto, exp_delay); end

        set_regs(4'd0, 8'd0, 8'd20, 1'b1);
        relive();
        send_pair(17'h1_0200, 32'h0000_00FF, 0, 1'b0, 1'b1, 3);
        tests++; if (ndelta !== 16'd1 || ntrig !== 16'd1) begin fails++; $display("FAIL rst_precondition: got %0d/%0d required 1/1", ndelta, ntrig); end
        #3 rst_n = 1'b0;
        #1;
        tests++; if (ndelta !== '0 || ntrig !== '0) begin fails++; $display("FAIL rst_async_counts: got %0d/%0d required 0/0", ndelta, ntrig); end
        tests++; if (et_raw !== '0 || veto_raw !== '0) begin fails++; $display("FAIL rst_async_raw: got %h/%h required 0/0", et_raw, veto_raw); end
        tests++; if (delay_et !== '0 || delay_veto !== '0 || out_lv1a !== 1'b0) begin fails++; $display("FAIL rst_async_delay: got %0d/%0d lv1a=%b required 0/0/0", delay_et, delay_veto, out_lv1a); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL live_pending: got %0d pulses missing required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_window();
        test_threshold();
        test_prescale();
        test_holdoff();
        test_live_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
